and3_bist_ctrl: RTL and testbench

//   Built-in self-test controller for a single and3 cell-under-test (CUT) on the test die.

---
 rtl/and3_bist_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_and3_bist_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/and3_bist_ctrl.sv
// and3_bist_ctrl: built-in self-test controller for a single and3 cell-under-test.
// It drives i0/i1/i2 with eight exhaustive patterns followed by LFSR patterns, waits
// SETTLE cycles, samples q against the expected AND and reports pass/fail, a
// saturating mismatch count and the index of the first failing pattern.
`timescale 1ns/1ps
module and3_bist_ctrl #(
   parameter logic [15:0] SEED   = 16'hACE1,
   parameter int          NPAT   = 256,
   parameter int          CNT_W  = 9,
   parameter int          SETTLE = 1,
   parameter int          ERR_W  = 8
) (
   input  logic             ck,
   input  logic             nrst,
   input  logic             start,
   input  logic             dut_q,
   output logic             dut_i0,
   output logic             dut_i1,
   output logic             dut_i2,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic [CNT_W-1:0] fail_idx
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_WAIT,
      S_CHECK,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NPAT - 1);
   // Patterns below this index are the exhaustive 000..111 sweep.
   localparam logic [CNT_W-1:0] LFSR_IDX  = CNT_W'(8);
   localparam logic [3:0]       SETTLE_L  = 4'(SETTLE);
   localparam logic [15:0]      LFSR_TAPS = 16'hB400;

   state_t            state;
   state_t            state_nxt;

   logic [15:0]       lfsr;
   logic [CNT_W-1:0]  pat_idx;
   logic              first_err;
   logic              exp_q;
   logic [3:0]        wcnt;

   logic              run_load;
   logic              drive_en;
   logic              check_en;
   logic              done_enter;

   logic [2:0]        pat;
   logic              mismatch;
   logic [ERR_W-1:0]  err_nxt;

   // Error counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (&v) ? v : v + ERR_W'(1);
   endfunction

   // One step of the 16-bit right-shifting Galois LFSR, feedback taken from bit 0.
   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
   endfunction

   assign pat      = (pat_idx < LFSR_IDX) ? pat_idx[2:0] : lfsr[2:0];
   assign mismatch = check_en && (dut_q != exp_q);
   assign err_nxt  = mismatch ? sat_inc(err_cnt) : err_cnt;

   // State register; reset aborts any run in progress.
   always_ff @(posedge ck or negedge nrst) begin
      if (!nrst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and per-state control strobes.
   always_comb begin
      state_nxt  = state;
      run_load   = 1'b0;
      drive_en   = 1'b0;
      check_en   = 1'b0;
      done_enter = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               run_load  = 1'b1;
               state_nxt = S_DRIVE;
            end
         end
         S_DRIVE: begin
            drive_en  = 1'b1;
            state_nxt = (SETTLE == 0) ? S_CHECK : S_WAIT;
         end
         S_WAIT: begin
            // wcnt holds the remaining settle cycles including this one.
            if (wcnt <= 4'd1) begin
               state_nxt = S_CHECK;
            end
         end
         S_CHECK: begin
            check_en = 1'b1;
            if (pat_idx == LAST_IDX) begin
               done_enter = 1'b1;
               state_nxt  = S_DONE;
            end else begin
               state_nxt  = S_DRIVE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Run bookkeeping, CUT drive and result reporting.
   always_ff @(posedge ck or negedge nrst) begin
      if (!nrst) begin
         dut_i0    <= 1'b0;
         dut_i1    <= 1'b0;
         dut_i2    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_cnt   <= '0;
         fail_idx  <= '0;
         lfsr      <= SEED;
         pat_idx   <= '0;
         first_err <= 1'b0;
      end else begin
         if (run_load) begin
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= '0;
            fail_idx  <= '0;
            first_err <= 1'b0;
            lfsr      <= SEED;
            pat_idx   <= '0;
         end
         if (drive_en) begin
            {dut_i2, dut_i1, dut_i0} <= pat;
         end
         if (check_en) begin
            err_cnt <= err_nxt;
            if (mismatch && !first_err) begin
               fail_idx  <= pat_idx;
               first_err <= 1'b1;
            end
            // The exhaustive sweep leaves the LFSR at SEED for pattern 8.
            if (pat_idx >= LFSR_IDX) begin
               lfsr <= lfsr_step(lfsr);
            end
            if (done_enter) begin
               busy                     <= 1'b0;
               done                     <= 1'b1;
               pass                     <= (err_nxt == '0);
               {dut_i2, dut_i1, dut_i0} <= 3'b000;
            end else begin
               pat_idx <= pat_idx + CNT_W'(1);
            end
         end
      end
   end

   // Expected response and settle counter; only meaningful while a run is active.
   always_ff @(posedge ck) begin
      if (drive_en) begin
         exp_q <= &pat;
         wcnt  <= SETTLE_L;
      end else if (state == S_WAIT) begin
         wcnt  <= wcnt - 4'd1;
      end
   end

endmodule

// File: tb/tb_and3_bist_ctrl.sv
// tb_and3_bist_ctrl: bench for and3_bist_ctrl with three instances
// (default parameters, ERR_W=4, SETTLE=0) each driving a modelled CUT.
`timescale 1ns/1ps
module tb_and3_bist_ctrl;

   localparam int          NPAT = 256;
   localparam logic [15:0] SEED = 16'hACE1;

   typedef struct {
      int inst;
      int mode;      // 0 golden, 1 stuck-at-0, 2 stuck-at-1
      int settle;
      bit mid_start;
      int exp_pass;
      int exp_err;
      int exp_fidx;
   } vec_t;

   typedef struct {
      int cycles;
      int pass;
      int err;
      int fidx;
   } res_t;

   logic       ck;
   logic       nrst;
   logic [2:0] start_v;
   logic [2:0] q_v;
   int         mode_v [3];
   wire  [2:0] i0_v, i1_v, i2_v, busy_v, done_v, pass_v;
   wire  [7:0] err0, err2;
   wire  [3:0] err1;
   wire  [8:0] fail0, fail1, fail2;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   exp_pat [NPAT];
   res_t sb_q [$];
   int   pat_q [$];
   vec_t vecs [8];

   and3_bist_ctrl u_dflt (
      .ck(ck), .nrst(nrst), .start(start_v[0]), .dut_q(q_v[0]),
      .dut_i0(i0_v[0]), .dut_i1(i1_v[0]), .dut_i2(i2_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
      .err_cnt(err0), .fail_idx(fail0));

   and3_bist_ctrl #(.ERR_W(4)) u_sat (
      .ck(ck), .nrst(nrst), .start(start_v[1]), .dut_q(q_v[1]),
      .dut_i0(i0_v[1]), .dut_i1(i1_v[1]), .dut_i2(i2_v[1]),
      .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
      .err_cnt(err1), .fail_idx(fail1));

   and3_bist_ctrl #(.SETTLE(0)) u_fast (
      .ck(ck), .nrst(nrst), .start(start_v[2]), .dut_q(q_v[2]),
      .dut_i0(i0_v[2]), .dut_i1(i1_v[2]), .dut_i2(i2_v[2]),
      .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
      .err_cnt(err2), .fail_idx(fail2));

   initial ck = 1'b0;
   always #5 ck = ~ck;

   // Modelled CUTs: a real and3 or one stuck at a constant.
   always_comb begin
      q_v = 3'b000;
      for (int j = 0; j < 3; j++) begin
         case (mode_v[j])
            0:       q_v[j] = i0_v[j] & i1_v[j] & i2_v[j];
            1:       q_v[j] = 1'b0;
            default: q_v[j] = 1'b1;
         endcase
      end
   end

   function automatic int get_err(int i);
      case (i)
         0:       return int'(err0);
         1:       return int'(err1);
         default: return int'(err2);
      endcase
   endfunction

   function automatic int get_fidx(int i);
      case (i)
         0:       return int'(fail0);
         1:       return int'(fail1);
         default: return int'(fail2);
      endcase
   endfunction

   function automatic int get_drv(int i);
      return int'({i2_v[i], i1_v[i], i0_v[i]});
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_zero_outputs(input int i, input string tag);
      chk({tag, "_busy"}, int'(busy_v[i]), 0);
      chk({tag, "_done"}, int'(done_v[i]), 0);
      chk({tag, "_pass"}, int'(pass_v[i]), 0);
      chk({tag, "_err"},  get_err(i), 0);
      chk({tag, "_fidx"}, get_fidx(i), 0);
      chk({tag, "_drv"},  get_drv(i), 0);
   endtask

   // One full run: expectations go into the scoreboard at start, are popped as the DUT produces them.
   task automatic run(input vec_t v);
      int   per;
      int   total;
      int   n;
      bit   got;
      res_t r;
      per   = v.settle + 2;
      total = NPAT * per;
      sb_q.push_back('{cycles: total, pass: v.exp_pass, err: v.exp_err, fidx: v.exp_fidx});
      for (int k = 0; k < NPAT; k++) pat_q.push_back(exp_pat[k]);
      @(negedge ck);
      mode_v[v.inst]  = v.mode;
      start_v[v.inst] = 1'b1;
      @(negedge ck);
      start_v[v.inst] = 1'b0;
      n = 0;
      chk("busy_rise", int'(busy_v[v.inst]), 1);
      chk("done_clear", int'(done_v[v.inst]), 0);
      got = 1'b0;
      while (!got && n < total + 20) begin
         @(negedge ck);
         n++;
         if (v.mid_start && n == 50) start_v[v.inst] = 1'b1;
         if (v.mid_start && n == 51) start_v[v.inst] = 1'b0;
         if (n <= total && (n - 1) % per == 0 && pat_q.size() > 0)
            chk("drive_pat", get_drv(v.inst), pat_q.pop_front());
         if (done_v[v.inst]) got = 1'b1;
      end
      chk("done_seen", int'(got), 1);
      chk("drive_count_left", pat_q.size(), 0);
      pat_q.delete();
      r = sb_q.pop_front();
      chk("run_cycles", n, r.cycles);
      chk("pass", int'(pass_v[v.inst]), r.pass);
      chk("err_cnt", get_err(v.inst), r.err);
      chk("fail_idx", get_fidx(v.inst), r.fidx);
      chk("busy_end", int'(busy_v[v.inst]), 0);
      chk("drv_end", get_drv(v.inst), 0);
      repeat (4) @(negedge ck);
      chk("done_held", int'(done_v[v.inst]), 1);
   endtask

   initial begin
      logic [15:0] l;
      int          c7;
      int          n;
      vec_t        g;

      // Reference pattern sequence: exhaustive sweep, then Galois LFSR low bits.
      l  = SEED;
      c7 = 0;
      for (int k = 0; k < NPAT; k++) begin
         if (k < 8) begin
            exp_pat[k] = k;
         end else begin
            exp_pat[k] = int'(l[2:0]);
            l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
         end
         if (exp_pat[k] == 7) c7++;
      end

      vecs[0] = '{inst: 0, mode: 0, settle: 1, mid_start: 0, exp_pass: 1, exp_err: 0, exp_fidx: 0};
      vecs[1] = '{inst: 0, mode: 1, settle: 1, mid_start: 0, exp_pass: 0, exp_err: c7, exp_fidx: 7};
      vecs[2] = '{inst: 1, mode: 2, settle: 1, mid_start: 0, exp_pass: 0,
                  exp_err: ((NPAT - c7) > 15) ? 15 : NPAT - c7, exp_fidx: 0};
      vecs[3] = '{inst: 0, mode: 2, settle: 1, mid_start: 0, exp_pass: 0,
                  exp_err: ((NPAT - c7) > 255) ? 255 : NPAT - c7, exp_fidx: 0};
      vecs[4] = '{inst: 0, mode: 0, settle: 1, mid_start: 1, exp_pass: 1, exp_err: 0, exp_fidx: 0};
      vecs[5] = '{inst: 0, mode: 0, settle: 1, mid_start: 0, exp_pass: 1, exp_err: 0, exp_fidx: 0};
      vecs[6] = '{inst: 2, mode: 0, settle: 0, mid_start: 0, exp_pass: 1, exp_err: 0, exp_fidx: 0};
      vecs[7] = '{inst: 1, mode: 0, settle: 1, mid_start: 0, exp_pass: 1, exp_err: 0, exp_fidx: 0};

      nrst    = 1'b0;
      start_v = 3'b000;
      for (int j = 0; j < 3; j++) mode_v[j] = 0;
      repeat (3) @(negedge ck);
      for (int j = 0; j < 3; j++) chk_zero_outputs(j, "reset");
      nrst = 1'b1;
      repeat (3) @(negedge ck);
      chk("idle_busy", int'(busy_v[0]), 0);

      for (int t = 0; t < 8; t++) run(vecs[t]);

      // Abort in WAIT of pattern 100 on a failing CUT so the counters are non-zero.
      @(negedge ck);
      mode_v[0]  = 1;
      start_v[0] = 1'b1;
      @(negedge ck);
      start_v[0] = 1'b0;
      n = 0;
      while (n < 301) begin
         @(negedge ck);
         n++;
      end
      chk("pre_abort_busy", int'(busy_v[0]), 1);
      chk("pre_abort_fidx", get_fidx(0), 7);
      nrst = 1'b0;
      #1;
      chk_zero_outputs(0, "abort");
      repeat (2) @(negedge ck);
      nrst = 1'b1;
      repeat (5) @(negedge ck);
      chk("post_abort_busy", int'(busy_v[0]), 0);
      chk("post_abort_done", int'(done_v[0]), 0);
      g = vecs[0];
      run(g);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
